// File: rtl/axil_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axil_pkg
// Purpose  : Shared types and constants for the AXI4-Lite initiator.
//            - state_e    : initiator FSM states
//            - axil_req_t : one core request (we, addr, wdata, wstrb)
//            - RESP_OKAY / RESP_ERR : 1-bit resp encoding on B and R
//            - PROT_DEFAULT : instruction, secure, unprivileged access
// Revision : 1.0 - initial release
// ============================================================================
package axil_pkg;

  localparam int AXIL_ADDR_W = 12;

  localparam logic RESP_OKAY = 1'b1;
  localparam logic RESP_ERR  = 1'b0;

  localparam logic [2:0] PROT_DEFAULT = 3'b100;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_RESP = 3'd4
  } state_e;

  typedef struct packed {
    logic                   we;
    logic [AXIL_ADDR_W-1:0] addr;
    logic [31:0]            wdata;
    logic [3:0]             wstrb;
  } axil_req_t;

endpackage
`default_nettype wire

// File: rtl/axil_req_skid.sv
`default_nettype none
// ============================================================================
// Module   : axil_req_skid
// Purpose  : One-entry request buffer. Holds a core request that arrived
//            while the initiator was busy until the FSM can launch it.
// Ports    : clk, reset  - clock, asynchronous active-high reset
//            push_i      - write data_i into the entry
//            pop_i       - entry consumed this cycle
//            data_i      - request to store
//            full_o      - entry holds a valid request
//            data_o      - stored request
// Revision : 1.0 - initial release
// ============================================================================
module axil_req_skid
  import axil_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      push_i,
  input  logic      pop_i,
  input  axil_req_t data_i,
  output logic      full_o,
  output axil_req_t data_o
);

  logic      full_q, full_d;
  axil_req_t data_q;

  // Push wins over pop: a request arriving on the drain cycle refills the
  // entry that is being freed.
  always_comb begin
    full_d = full_q;
    if (pop_i)  full_d = 1'b0;
    if (push_i) full_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      if (push_i) data_q <= data_i;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule
`default_nettype wire

// File: rtl/axil_master.sv
`default_nettype none
// ============================================================================
// Module   : axil_master
// Purpose  : AXI4-Lite initiator. Converts a single-outstanding core
//            request/response port into AXI-Lite reads and writes. All AXI
//            outputs are registered; one transaction is on the bus at a time.
// Params   : ADDR_W - address width, PROT - value driven on awprot/arprot
// Ports    : clk, reset (asynchronous, active-high)
//            req_*  - core request (valid/ready, we, addr, wdata, wstrb)
//            rsp_*  - one-cycle response pulse with rdata and err
//            aw*/w*/b*/ar*/r* - AXI-Lite initiator channels
// Config   : AXIL_MASTER_SKID_EN - adds a one-entry request buffer so a new
//            request can be accepted while a transaction is in flight.
// Revision : 1.0 - initial release
// ============================================================================
module axil_master
  import axil_pkg::*;
#(
  parameter int         ADDR_W = AXIL_ADDR_W,
  parameter logic [2:0] PROT   = PROT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  // core request / response
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  // AW
  output logic              awvalid,
  input  logic              awready,
  output logic [ADDR_W-1:0] awaddr,
  output logic [2:0]        awprot,
  // W
  output logic              wvalid,
  input  logic              wready,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  // B
  input  logic              bvalid,
  output logic              bready,
  input  logic              bresp,
  // AR
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [2:0]        arprot,
  // R
  input  logic              rvalid,
  output logic              rready,
  input  logic [31:0]       rdata,
  input  logic              rresp
);

  state_e            state_q, state_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
  logic [ADDR_W-1:0] araddr_q, awaddr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic              rsp_valid_q, rsp_err_q;
  logic [31:0]       rsp_rdata_q;

  logic              rd_done, wr_done, complete, launch;
  axil_req_t         in_req, launch_req;

  assign in_req.we    = req_we;
  assign in_req.addr  = AXIL_ADDR_W'(req_addr);
  assign in_req.wdata = req_wdata;
  assign in_req.wstrb = req_wstrb;

  assign rd_done  = rready_q & rvalid;
  assign wr_done  = bready_q & bvalid;
  assign complete = rd_done | wr_done;

`ifdef AXIL_MASTER_SKID_EN
  logic      can_launch, skid_full, skid_push, skid_pop, launch_direct;
  axil_req_t skid_req;

  // A new transaction may start from IDLE or on the completion cycle of the
  // current one; a buffered request always goes before the live port.
  assign can_launch    = (state_q == IDLE) | complete;
  assign skid_pop      = can_launch & skid_full;
  assign req_ready     = ~skid_full | skid_pop;
  assign launch_direct = can_launch & ~skid_full & req_valid;
  assign skid_push     = req_valid & req_ready & ~launch_direct;
  assign launch        = skid_pop | launch_direct;
  assign launch_req    = skid_full ? skid_req : in_req;

  axil_req_skid u_skid (
    .clk    (clk),
    .reset  (reset),
    .push_i (skid_push),
    .pop_i  (skid_pop),
    .data_i (in_req),
    .full_o (skid_full),
    .data_o (skid_req)
  );
`else
  assign req_ready  = (state_q == IDLE);
  assign launch     = req_valid & req_ready;
  assign launch_req = in_req;
`endif

  // Next-state logic. aw_done/w_done record which write handshakes have
  // already happened so each valid drops independently.
  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (state_q)
      IDLE:    state_d = IDLE;
      RD_ADDR: if (arvalid_q && arready) state_d = RD_DATA;
      RD_DATA: if (rd_done) state_d = IDLE;
      WR_ADDR: begin
        if (awvalid_q && awready) aw_done_d = 1'b1;
        if (wvalid_q && wready)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) begin
          state_d   = WR_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WR_RESP: if (wr_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (launch) begin
      state_d   = launch_req.we ? WR_ADDR : RD_ADDR;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end
  end

  // AXI outputs are registered copies of what the next state demands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      araddr_q    <= '0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      arvalid_q   <= (state_d == RD_ADDR);
      rready_q    <= (state_d == RD_DATA);
      bready_q    <= (state_d == WR_RESP);
      awvalid_q   <= (state_d == WR_ADDR) && !aw_done_d;
      wvalid_q    <= (state_d == WR_ADDR) && !w_done_d;
      rsp_valid_q <= complete;
      if (launch && !launch_req.we) begin
        araddr_q <= ADDR_W'(launch_req.addr);
      end
      if (launch && launch_req.we) begin
        awaddr_q <= ADDR_W'(launch_req.addr);
        wdata_q  <= launch_req.wdata;
        wstrb_q  <= launch_req.wstrb;
      end
      if (rd_done) begin
        rsp_rdata_q <= rdata;
        rsp_err_q   <= (rresp == RESP_ERR);
      end else if (wr_done) begin
        rsp_rdata_q <= '0;
        rsp_err_q   <= (bresp == RESP_ERR);
      end
    end
  end

  assign awvalid   = awvalid_q;
  assign awaddr    = awaddr_q;
  assign awprot    = PROT;
  assign wvalid    = wvalid_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign bready    = bready_q;
  assign arvalid   = arvalid_q;
  assign araddr    = araddr_q;
  assign arprot    = PROT;
  assign rready    = rready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire
